// File: rtl/piso_tx_scheduler_pkg.sv
// Shared definitions for the PISO transmit scheduler: FSM encodings,
// default build parameters and the counter-width helper.
package piso_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DEF_W   = 32;
  localparam int DEF_GAP = 1;

  // The counter must hold both W-1 (bits left) and GAP-1 (idle cycles left).
  function automatic int cnt_width(input int w, input int gap);
    int m;
    m = (w > gap + 1) ? w : gap + 1;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/piso_tx_scheduler_shift_core.sv
// W-bit parallel-in/serial-out register: synchronous load, MSB-first shift
// with zero fill. Serial output is always the register MSB.
module piso_shift_core #(
  parameter int W = 32
) (
  input  logic         C,
  input  logic         RN,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] pi,
  output logic         so
);

  logic [W-1:0] shreg_q;
  logic [W-1:0] shreg_d;

  // Next register value: load has priority over shift.
  always_comb begin
    shreg_d = shreg_q;
    if (load) begin
      shreg_d = pi;
    end else if (shift_en) begin
      shreg_d = {shreg_q[W-2:0], 1'b0};
    end
  end

  // Shift register state with synchronous active-low clear.
  always_ff @(posedge C) begin
    if (!RN) begin
      shreg_q <= '0;
    end else begin
      shreg_q <= shreg_d;
    end
  end

  assign so = shreg_q[W-1];

endmodule

// File: rtl/piso_tx_scheduler.sv
// Round-robin scheduler sharing one PISO shifter between two word sources.
// Top level holds the FSM, bit/gap counter, round-robin pointer and RDY logic.
module piso_tx_scheduler
  import piso_tx_scheduler_pkg::*;
#(
  parameter int W   = DEF_W,
  parameter int GAP = DEF_GAP
) (
  input  logic         C,
  input  logic         RN,
  input  logic         REQ0_V,
  input  logic [W-1:0] REQ0_D,
  output logic         REQ0_RDY,
  input  logic         REQ1_V,
  input  logic [W-1:0] REQ1_D,
  output logic         REQ1_RDY,
  output logic         SO,
  output logic         SO_V,
  output logic         DONE,
  output logic         BUSY,
  output logic         GNT_ID
);

  localparam int CNT_W = cnt_width(W, GAP);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(W - 1);
  localparam logic [CNT_W-1:0] CNT_HOLD  = CNT_W'((GAP > 0) ? GAP - 1 : 0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rr_ptr_q, rr_ptr_d;
  logic             gnt_id_q, gnt_id_d;

  logic idle;
  logic rdy0;
  logic rdy1;
  logic accept;
  logic shift_en;
  logic core_so;

  // Arbitration: only in IDLE; a lone requester wins, a tie goes to rr_ptr.
  always_comb begin
    idle   = (state_q == ST_IDLE);
    rdy0   = idle && REQ0_V && (!REQ1_V || !rr_ptr_q);
    rdy1   = idle && REQ1_V && (!REQ0_V ||  rr_ptr_q);
    accept = rdy0 || rdy1;
  end

  // Next-state, counter, pointer and grant computation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    gnt_id_d = gnt_id_q;
    shift_en = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          rr_ptr_d = ~rdy1;
          gnt_id_d = rdy1;
          cnt_d    = CNT_FRAME;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        if (cnt_q == '0) begin
          if (GAP > 0) begin
            state_d = ST_HOLD;
            cnt_d   = CNT_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state; reset aborts any frame in flight.
  always_ff @(posedge C) begin
    if (!RN) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= 1'b0;
      gnt_id_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      gnt_id_q <= gnt_id_d;
    end
  end

  piso_shift_core #(.W(W)) u_core (
    .C        (C),
    .RN       (RN),
    .load     (accept),
    .shift_en (shift_en),
    .pi       (rdy1 ? REQ1_D : REQ0_D),
    .so       (core_so)
  );

  assign REQ0_RDY = rdy0;
  assign REQ1_RDY = rdy1;
  assign SO_V     = (state_q == ST_SHIFT);
  assign SO       = SO_V && core_so;
  assign DONE     = SO_V && (cnt_q == '0);
  assign BUSY     = !idle;
  assign GNT_ID   = gnt_id_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// Self-checking bench: scoreboard of accepted words compared against the
// reassembled serial frames, plus per-scenario timing/arbitration checks.
module tb_piso_tx_scheduler;
  localparam int W = 32;

  logic C = 1'b0;
  always #5 C = ~C;

  // Main DUT (GAP=1)
  logic RN = 1'b0;
  logic req0_v = 1'b0, req1_v = 1'b0;
  logic [W-1:0] req0_d = '0, req1_d = '0;
  logic rdy0, rdy1, so, so_v, done, busy, gnt_id;

  // GAP=0 DUT
  logic g_rn = 1'b0;
  logic g_v0 = 1'b0, g_v1 = 1'b0;
  logic [W-1:0] g_d0 = '0, g_d1 = '0;
  logic g_rdy0, g_rdy1, g_so, g_so_v, g_done, g_busy, g_gnt;

  piso_tx_scheduler #(.W(W), .GAP(1)) dut (
    .C(C), .RN(RN),
    .REQ0_V(req0_v), .REQ0_D(req0_d), .REQ0_RDY(rdy0),
    .REQ1_V(req1_v), .REQ1_D(req1_d), .REQ1_RDY(rdy1),
    .SO(so), .SO_V(so_v), .DONE(done), .BUSY(busy), .GNT_ID(gnt_id)
  );

  piso_tx_scheduler #(.W(W), .GAP(0)) dut0 (
    .C(C), .RN(g_rn),
    .REQ0_V(g_v0), .REQ0_D(g_d0), .REQ0_RDY(g_rdy0),
    .REQ1_V(g_v1), .REQ1_D(g_d1), .REQ1_RDY(g_rdy1),
    .SO(g_so), .SO_V(g_so_v), .DONE(g_done), .BUSY(g_busy), .GNT_ID(g_gnt)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  logic [W:0]   sb_q[$];   // {source, word} expected per frame
  int           acc_src[$];
  int           acc_t[$];
  logic [W-1:0] col;
  int           ncol;

  always @(posedge C) cyc <= cyc + 1;

  // Monitor on the main DUT: record accepts, rebuild frames, score them.
  initial begin
    logic [W:0] exp_e;
    col = '0;
    ncol = 0;
    forever begin
      @(negedge C);
      if (!RN) begin
        sb_q.delete();
        col = '0;
        ncol = 0;
      end else begin
        total_cnt++;
        if (rdy0 && rdy1) $display("FAIL one_rdy: rdy0=%b rdy1=%b required at most one", rdy0, rdy1);
        else pass_cnt++;
        if (so_v) begin
          col = {col[W-2:0], so};
          ncol++;
        end else begin
          total_cnt++;
          if (so !== 1'b0) $display("FAIL so_idle: so=%b required 0 while so_v=0", so);
          else pass_cnt++;
        end
        if (done) begin
          total_cnt++;
          if (sb_q.size() == 0) begin
            $display("FAIL frame: unexpected DONE, gnt=%0d word=%h", gnt_id, col);
          end else begin
            exp_e = sb_q.pop_front();
            if ({gnt_id, col} !== exp_e || ncol != W)
              $display("FAIL frame: gnt=%0d word=%h bits=%0d required gnt=%0d word=%h bits=%0d",
                       gnt_id, col, ncol, exp_e[W], exp_e[W-1:0], W);
            else begin
              pass_cnt++;
              $display("frame ok: src=%0d word=%h", gnt_id, col);
            end
          end
          col = '0;
          ncol = 0;
        end
        if (req0_v && rdy0) begin
          sb_q.push_back({1'b0, req0_d});
          acc_src.push_back(0);
          acc_t.push_back(cyc);
        end
        if (req1_v && rdy1) begin
          sb_q.push_back({1'b1, req1_d});
          acc_src.push_back(1);
          acc_t.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge C);
    #1;
  endtask

  task automatic do_reset();
    RN = 1'b0;
    req0_v = 1'b0;
    req1_v = 1'b0;
    step();
    step();
    acc_src.delete();
    acc_t.delete();
    RN = 1'b1;
  endtask

  task automatic wait_accept(input int base);
    for (int i = 0; i < 100 && acc_src.size() == base; i++) step();
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 200; i++) begin
      @(negedge C);
      if (!busy && sb_q.size() == 0) break;
    end
    total_cnt++;
    if (i >= 200) $display("FAIL drain: busy=%b pending=%0d required idle and empty", busy, sb_q.size());
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset();
    RN = 1'b0;
    step();
    @(negedge C);
    total_cnt++;
    if ({so, so_v, done, busy, gnt_id} !== 5'b0)
      $display("FAIL reset_outs: so/so_v/done/busy/gnt=%b required 00000", {so, so_v, done, busy, gnt_id});
    else pass_cnt++;
    req1_v = 1'b1;
    #1;
    total_cnt++;
    if ({rdy0, rdy1} !== 2'b01) $display("FAIL reset_rdy: rdy=%b required 01", {rdy0, rdy1});
    else pass_cnt++;
    req1_v = 1'b0;
    do_reset();
  endtask

  task automatic test_single();
    logic [W-1:0] ew;
    int n;
    ew = 32'hD0492087;
    do_reset();
    req0_d = ew;
    req0_v = 1'b1;
    @(negedge C);
    total_cnt++;
    if ({rdy0, rdy1} !== 2'b10) $display("FAIL single_rdy: rdy0/rdy1=%b required 10", {rdy0, rdy1});
    else pass_cnt++;
    step();
    req0_v = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge C);
      total_cnt++;
      if ({so_v, so} !== {1'b1, ew[31-i]})
        $display("FAIL single_bit%0d: so_v/so=%b required 1%b", i, {so_v, so}, ew[31-i]);
      else pass_cnt++;
    end
    for (n = 0; n < 40; n++) begin
      @(negedge C);
      if (done) break;
    end
    total_cnt++;
    if (n != W - 5) $display("FAIL single_done: done after %0d more bits required %0d", n, W - 5);
    else pass_cnt++;
    @(negedge C);
    total_cnt++;
    if ({busy, so_v} !== 2'b10) $display("FAIL single_hold: busy/so_v=%b required 10", {busy, so_v});
    else pass_cnt++;
    @(negedge C);
    total_cnt++;
    if (busy !== 1'b0) $display("FAIL single_idle: busy=%b required 0", busy);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_alternate();
    do_reset();
    req0_d = 32'hAAAA5555;
    req1_d = 32'h0F0F0F0F;
    req0_v = 1'b1;
    req1_v = 1'b1;
    for (int i = 0; i < 300 && acc_src.size() < 4; i++) step();
    req0_v = 1'b0;
    req1_v = 1'b0;
    total_cnt++;
    if (acc_src.size() != 4) $display("FAIL alt_count: accepts=%0d required 4", acc_src.size());
    else begin
      pass_cnt++;
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (acc_src[k] != k % 2) $display("FAIL alt_src%0d: src=%0d required %0d", k, acc_src[k], k % 2);
        else pass_cnt++;
      end
      for (int k = 1; k < 4; k++) begin
        total_cnt++;
        if (acc_t[k] - acc_t[k-1] != W + 2)
          $display("FAIL alt_space%0d: spacing=%0d required %0d", k, acc_t[k] - acc_t[k-1], W + 2);
        else pass_cnt++;
      end
    end
    drain();
  endtask

  task automatic test_only1();
    logic [W-1:0] words [3];
    words[0] = 32'h80000001;
    words[1] = 32'h7FFFFFFE;
    words[2] = 32'hC3A55A3C;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      req1_d = words[k];
      req1_v = 1'b1;
      wait_accept(k);
    end
    req1_v = 1'b0;
    total_cnt++;
    if (acc_src.size() != 3) $display("FAIL only1_count: accepts=%0d required 3", acc_src.size());
    else begin
      pass_cnt++;
      for (int k = 0; k < 3; k++) begin
        total_cnt++;
        if (acc_src[k] != 1) $display("FAIL only1_src%0d: src=%0d required 1", k, acc_src[k]);
        else pass_cnt++;
      end
      for (int k = 1; k < 3; k++) begin
        total_cnt++;
        if (acc_t[k] - acc_t[k-1] != W + 2)
          $display("FAIL only1_space%0d: spacing=%0d required %0d", k, acc_t[k] - acc_t[k-1], W + 2);
        else pass_cnt++;
      end
    end
    drain();
  endtask

  task automatic test_reset_mid();
    int base;
    do_reset();
    req0_d = 32'h12345678;
    req0_v = 1'b1;
    wait_accept(0);
    req0_v = 1'b0;
    repeat (9) step();
    RN = 1'b0;
    step();
    RN = 1'b1;
    @(negedge C);
    total_cnt++;
    if ({so, so_v, busy, done} !== 4'b0)
      $display("FAIL abort_outs: so/so_v/busy/done=%b required 0000", {so, so_v, busy, done});
    else pass_cnt++;
    step();
    base = acc_src.size();
    req0_d = 32'hCAFE0123;
    req1_d = 32'h13579BDF;
    req0_v = 1'b1;
    req1_v = 1'b1;
    wait_accept(base);
    req0_v = 1'b0;
    req1_v = 1'b0;
    total_cnt++;
    if (acc_src.size() != base + 1 || acc_src[acc_src.size()-1] != 0)
      $display("FAIL abort_prio: accepts=%0d last_src=%0d required %0d and 0",
               acc_src.size() - base, acc_src[acc_src.size()-1], 1);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_gap0();
    logic [W-1:0] wa, wb, got;
    logic rdy_seen, sov_bad;
    int t0, i;
    wa = 32'hDEADBEEF;
    wb = 32'h00C0FFEE;
    g_rn = 1'b0;
    step();
    step();
    g_rn = 1'b1;
    g_d0 = wa;
    g_v0 = 1'b1;
    for (i = 0; i < 10; i++) begin
      @(negedge C);
      if (g_rdy0) break;
    end
    total_cnt++;
    if (g_rdy0 !== 1'b1) $display("FAIL gap0_rdy0: rdy0=%b required 1", g_rdy0);
    else pass_cnt++;
    t0 = cyc;
    step();
    g_v0 = 1'b0;
    g_d1 = wb;
    g_v1 = 1'b1;
    got = '0;
    rdy_seen = 1'b0;
    sov_bad = 1'b0;
    for (int b = 0; b < W; b++) begin
      @(negedge C);
      got = {got[W-2:0], g_so};
      if (g_rdy0 || g_rdy1) rdy_seen = 1'b1;
      if (!g_so_v) sov_bad = 1'b1;
    end
    total_cnt++;
    if (got !== wa || sov_bad) $display("FAIL gap0_frame: word=%h so_v_gap=%b required %h 0", got, sov_bad, wa);
    else pass_cnt++;
    total_cnt++;
    if (rdy_seen !== 1'b0) $display("FAIL gap0_rdy_shift: rdy seen=%b required 0", rdy_seen);
    else pass_cnt++;
    total_cnt++;
    if (g_done !== 1'b1) $display("FAIL gap0_done: done=%b required 1", g_done);
    else pass_cnt++;
    @(negedge C);
    total_cnt++;
    if (g_rdy1 !== 1'b1 || cyc - t0 != W + 1)
      $display("FAIL gap0_period: rdy1=%b period=%0d required 1 %0d", g_rdy1, cyc - t0, W + 1);
    else pass_cnt++;
    step();
    g_v1 = 1'b0;
    got = '0;
    for (int b = 0; b < W; b++) begin
      @(negedge C);
      got = {got[W-2:0], g_so};
    end
    total_cnt++;
    if (got !== wb || g_gnt !== 1'b1) $display("FAIL gap0_frame2: word=%h gnt=%b required %h 1", got, g_gnt, wb);
    else pass_cnt++;
    step();
  endtask

  task automatic test_pulse();
    int base;
    do_reset();
    req1_d = 32'h5A5A0001;
    req1_v = 1'b1;
    wait_accept(0);
    req1_v = 1'b0;
    repeat (5) step();
    req0_d = 32'hFFFF0000;
    req0_v = 1'b1;
    @(negedge C);
    total_cnt++;
    if ({rdy0, busy} !== 2'b01) $display("FAIL pulse_rdy: rdy0/busy=%b required 01", {rdy0, busy});
    else pass_cnt++;
    step();
    req0_v = 1'b0;
    base = acc_src.size();
    drain();
    repeat (40) step();
    total_cnt++;
    if (acc_src.size() != base || busy !== 1'b0)
      $display("FAIL pulse_noframe: extra accepts=%0d busy=%b required 0 0", acc_src.size() - base, busy);
    else pass_cnt++;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_only1();
    test_reset_mid();
    test_gap0();
    test_pulse();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
